// File: rtl/rfg_axis_protocol_fifo_arbiter_if.sv
// Requester streams and the FIFO write port bundled as one interface.
// The arbiter uses the slave modport; the environment uses master.
interface rfg_axis_protocol_fifo_arbiter_if #(
  parameter int NREQ = 2
) ();
  logic [NREQ-1:0]   req_tvalid;
  logic [NREQ-1:0]   req_tready;
  logic [8*NREQ-1:0] req_tdata;
  logic [NREQ-1:0]   req_tlast;
  logic              fifo_write;
  logic [7:0]        fifo_write_value;
  logic              fifo_full;

  // Arbiter side: consumes requester streams, drives the FIFO write port.
  modport slave (
    input  req_tvalid,
    input  req_tdata,
    input  req_tlast,
    input  fifo_full,
    output req_tready,
    output fifo_write,
    output fifo_write_value
  );

  // Environment side: sources the streams, models the FIFO.
  modport master (
    output req_tvalid,
    output req_tdata,
    output req_tlast,
    output fifo_full,
    input  req_tready,
    input  fifo_write,
    input  fifo_write_value
  );
endinterface

// File: rtl/rfg_axis_protocol_fifo_arbiter.sv
// Packet-granular round-robin arbiter that multiplexes NREQ byte streams
// onto one FIFO write port, prefixing every packet with a source header
// byte {HDR_TAG, 1'b0, idx} so the reader can demultiplex.
module rfg_axis_protocol_fifo_arbiter #(
  parameter int         NREQ    = 2,
  parameter logic [3:0] HDR_TAG = 4'hA
) (
  input  logic                                  clk,
  input  logic                                  res,
  input  logic                                  enable,
  rfg_axis_protocol_fifo_arbiter_if.slave       bus,
  output logic [NREQ-1:0]                       grant,
  output logic                                  busy,
  output logic [15:0]                           pkt_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2
  } state_t;

  state_t          state_q;
  logic [NREQ-1:0] grant_q;
  logic [2:0]      idx_q;
  logic [2:0]      last_q;
  logic            busy_q;
  logic [15:0]     pkt_count_q;

  // Requester vectors widened to the 8-requester maximum so a 3-bit index
  // selects them directly for any NREQ.
  logic [7:0]  vld8;
  logic [7:0]  last8;
  logic [63:0] data8;
  logic [7:0]  rdy8;

  assign vld8  = 8'(bus.req_tvalid);
  assign last8 = 8'(bus.req_tlast);
  assign data8 = 64'(bus.req_tdata);

  logic            found_d;
  logic [2:0]      pick_d;
  logic [NREQ-1:0] grant_d;
  logic            xfer_d;

  // Round-robin search starting just after the previous owner.
  always_comb begin
    logic [3:0] s;
    found_d = 1'b0;
    pick_d  = last_q;
    s       = 4'd0;
    for (int k = 1; k <= NREQ; k++) begin
      s = {1'b0, last_q} + 4'(k);
      if (s >= 4'(NREQ)) s = s - 4'(NREQ);
      if (!found_d && vld8[s[2:0]]) begin
        found_d = 1'b1;
        pick_d  = s[2:0];
      end
    end
    grant_d = NREQ'(8'b1 << pick_d);
  end

  // A data byte moves only when the owner is valid and the FIFO has room.
  assign xfer_d = (state_q == DATA) && vld8[idx_q] && !bus.fifo_full;

  // Control FSM: grant on packet start, header, then data until tlast.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      idx_q       <= 3'd0;
      last_q      <= 3'(NREQ - 1);
      busy_q      <= 1'b0;
      pkt_count_q <= 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable && found_d) begin
            grant_q <= grant_d;
            idx_q   <= pick_d;
            last_q  <= pick_d;
            busy_q  <= 1'b1;
            state_q <= HEADER;
          end
        end
        HEADER: begin
          if (!bus.fifo_full) state_q <= DATA;
        end
        DATA: begin
          if (xfer_d && last8[idx_q]) begin
            grant_q     <= '0;
            busy_q      <= 1'b0;
            pkt_count_q <= pkt_count_q + 16'd1;
            state_q     <= IDLE;
          end
        end
        default: begin
          grant_q <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // FIFO write port and requester ready, decoded from the current state.
  always_comb begin
    bus.fifo_write       = 1'b0;
    bus.fifo_write_value = 8'h00;
    rdy8                 = 8'h00;
    case (state_q)
      HEADER: begin
        bus.fifo_write = !bus.fifo_full;
        if (!bus.fifo_full) bus.fifo_write_value = {HDR_TAG, 1'b0, idx_q};
      end
      DATA: begin
        rdy8[idx_q]    = !bus.fifo_full;
        bus.fifo_write = xfer_d;
        if (xfer_d) bus.fifo_write_value = data8[{idx_q, 3'b000} +: 8];
      end
      default: begin
        bus.fifo_write = 1'b0;
      end
    endcase
  end

  assign bus.req_tready = rdy8[NREQ-1:0];
  assign grant          = grant_q;
  assign busy           = busy_q;
  assign pkt_count      = pkt_count_q;

endmodule

// File: tb/tb_rfg_axis_protocol_fifo_arbiter.sv
// Directed bench for rfg_axis_protocol_fifo_arbiter with NREQ=2.
// Expected FIFO bytes are queued as packets are offered and popped as the
// DUT writes them.
module tb_rfg_axis_protocol_fifo_arbiter;

  localparam int NREQ = 2;

  logic            clk = 1'b0;
  logic            res;
  logic            enable;
  logic [NREQ-1:0] grant;
  logic            busy;
  logic [15:0]     pkt_count;

  rfg_axis_protocol_fifo_arbiter_if #(.NREQ(NREQ)) bus ();

  rfg_axis_protocol_fifo_arbiter #(.NREQ(NREQ), .HDR_TAG(4'hA)) dut (
    .clk       (clk),
    .res       (res),
    .enable    (enable),
    .bus       (bus.slave),
    .grant     (grant),
    .busy      (busy),
    .pkt_count (pkt_count)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [8:0] src0[$];
  logic [8:0] src1[$];
  logic [1:0] hold = 2'b00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.req_tvalid[0]  = (src0.size() != 0) && !hold[0];
    bus.req_tdata[7:0] = (src0.size() != 0) ? src0[0][7:0] : 8'h00;
    bus.req_tlast[0]   = (src0.size() != 0) ? src0[0][8] : 1'b0;
    bus.req_tvalid[1]  = (src1.size() != 0) && !hold[1];
    bus.req_tdata[15:8] = (src1.size() != 0) ? src1[0][7:0] : 8'h00;
    bus.req_tlast[1]   = (src1.size() != 0) ? src1[0][8] : 1'b0;
  endtask

  // Queue a byte at a source and also expect it in the FIFO.
  task automatic put(input int s, input logic [7:0] b, input logic l);
    if (s == 0) src0.push_back({l, b});
    else        src1.push_back({l, b});
    exp_q.push_back(b);
  endtask

  task automatic hdr(input int s);
    exp_q.push_back(8'hA0 | 8'(s));
  endtask

  // One clock: check FIFO writes at the negedge, retire handshakes after posedge.
  task automatic tick();
    logic [1:0] hs;
    logic [7:0] e;
    @(negedge clk);
    if (bus.fifo_write) begin
      if (exp_q.size() == 0) chk("fifo_write_unexpected", 32'(exp_q.size()), 32'd1);
      else begin
        e = exp_q.pop_front();
        chk("fifo_byte", 32'(bus.fifo_write_value), 32'(e));
      end
    end else begin
      chk("fifo_value_idle", 32'(bus.fifo_write_value), 32'd0);
    end
    chk("tready_outside_grant", 32'(bus.req_tready & ~grant), 32'd0);
    chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
    hs = bus.req_tvalid & bus.req_tready;
    @(posedge clk);
    #1;
    if (hs[0]) void'(src0.pop_front());
    if (hs[1]) void'(src1.pop_front());
    drive();
  endtask

  task automatic run_done(input string tag, input int n);
    int k = 0;
    while ((exp_q.size() != 0 || busy || src0.size() != 0 || src1.size() != 0) && k < n) begin
      tick();
      k++;
    end
    chk(tag, 32'(k < n), 32'd1);
  endtask

  initial begin
    res           = 1'b1;
    enable        = 1'b0;
    bus.fifo_full = 1'b0;
    drive();
    tick();
    tick();
    // Reset state
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pkt", 32'(pkt_count), 32'd0);
    chk("rst_write", 32'(bus.fifo_write), 32'd0);
    chk("rst_tready", 32'(bus.req_tready), 32'd0);
    res = 1'b0;
    tick();

    // Single source: A0,11,22,33 with latency N+1 header, N+2 data
    enable = 1'b1;
    hdr(0); put(0, 8'h11, 1'b0); put(0, 8'h22, 1'b0); put(0, 8'h33, 1'b1);
    drive();
    chk("t1_idle_busy", 32'(busy), 32'd0);
    tick();
    chk("t1_hdr_busy", 32'(busy), 32'd1);
    chk("t1_hdr_grant", 32'(grant), 32'd1);
    chk("t1_hdr_write", 32'(bus.fifo_write), 32'd1);
    tick();
    chk("t1_data_write", 32'(bus.fifo_write), 32'd1);
    chk("t1_data_tready", 32'(bus.req_tready), 32'd1);
    run_done("t1_timeout", 40);
    chk("t1_pkt", 32'(pkt_count), 32'd1);
    chk("t1_grant_end", 32'(grant), 32'd0);

    // Round-robin: both valid, 1-byte packets; last owner was 0 so 1 leads
    hdr(1); put(1, 8'h60, 1'b1);
    hdr(0); put(0, 8'h50, 1'b1);
    hdr(1); put(1, 8'h61, 1'b1);
    hdr(0); put(0, 8'h51, 1'b1);
    drive();
    run_done("t2_timeout", 60);
    chk("t2_pkt", 32'(pkt_count), 32'd5);

    // Backpressure during HEADER
    hdr(1); put(1, 8'h71, 1'b0); put(1, 8'h72, 1'b1);
    drive();
    tick();
    bus.fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_full_nowrite", 32'(bus.fifo_write), 32'd0);
      chk("t3_full_busy", 32'(busy), 32'd1);
      chk("t3_full_grant", 32'(grant), 32'd2);
    end
    bus.fifo_full = 1'b0;
    run_done("t3_timeout", 40);
    chk("t3_pkt", 32'(pkt_count), 32'd6);

    // Backpressure mid-DATA
    hdr(0); put(0, 8'h81, 1'b0); put(0, 8'h82, 1'b0); put(0, 8'h83, 1'b1);
    drive();
    tick();
    tick();
    tick();
    bus.fifo_full = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t4_full_tready", 32'(bus.req_tready), 32'd0);
      chk("t4_full_nowrite", 32'(bus.fifo_write), 32'd0);
    end
    bus.fifo_full = 1'b0;
    run_done("t4_timeout", 40);
    chk("t4_pkt", 32'(pkt_count), 32'd7);

    // Grant held while owner drops tvalid and req1 waits
    hdr(0); put(0, 8'h91, 1'b0); put(0, 8'h92, 1'b0); put(0, 8'h93, 1'b1);
    drive();
    tick();
    hdr(1); put(1, 8'hA5, 1'b1);
    drive();
    tick();
    tick();
    hold[0] = 1'b1;
    drive();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_hold_grant", 32'(grant), 32'd1);
      chk("t5_hold_nowrite", 32'(bus.fifo_write), 32'd0);
    end
    hold[0] = 1'b0;
    drive();
    run_done("t5_timeout", 40);
    chk("t5_pkt", 32'(pkt_count), 32'd9);

    // enable low mid-packet: packet completes, next grant blocked
    hdr(0); put(0, 8'hC1, 1'b0); put(0, 8'hC2, 1'b1);
    drive();
    tick();
    enable = 1'b0;
    hdr(1); put(1, 8'hD1, 1'b1);
    drive();
    begin
      int k = 0;
      while ((src0.size() != 0 || busy) && k < 40) begin
        tick();
        k++;
      end
      chk("t6_drain_timeout", 32'(k < 40), 32'd1);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_blocked_grant", 32'(grant), 32'd0);
      chk("t6_blocked_busy", 32'(busy), 32'd0);
      chk("t6_blocked_write", 32'(bus.fifo_write), 32'd0);
    end
    chk("t6_pkt_mid", 32'(pkt_count), 32'd10);
    enable = 1'b1;
    tick();
    chk("t6_resume_grant", 32'(grant), 32'd2);
    chk("t6_resume_hdr", 32'(bus.fifo_write), 32'd1);
    run_done("t6_timeout", 40);
    chk("t6_pkt", 32'(pkt_count), 32'd11);

    // Reset mid-DATA; afterwards requester 0 has first priority again
    hdr(0);
    put(0, 8'hE1, 1'b0);
    src0.push_back({1'b0, 8'hE2});
    src0.push_back({1'b0, 8'hE3});
    src0.push_back({1'b1, 8'hE4});
    src1.push_back({1'b1, 8'hF1});
    drive();
    tick();
    tick();
    tick();
    chk("t7_pre_reset_drained", 32'(exp_q.size()), 32'd0);
    res = 1'b1;
    #1;
    chk("t7_rst_grant", 32'(grant), 32'd0);
    chk("t7_rst_busy", 32'(busy), 32'd0);
    chk("t7_rst_pkt", 32'(pkt_count), 32'd0);
    chk("t7_rst_write", 32'(bus.fifo_write), 32'd0);
    chk("t7_rst_tready", 32'(bus.req_tready), 32'd0);
    src0.delete();
    src1.delete();
    drive();
    tick();
    res = 1'b0;
    hdr(0); put(0, 8'hB1, 1'b1);
    hdr(1); put(1, 8'hF1, 1'b1);
    drive();
    tick();
    chk("t7_first_grant", 32'(grant), 32'd1);
    run_done("t7_timeout", 40);
    chk("t7_pkt", 32'(pkt_count), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
